keyboard_ps2_ctrl: RTL and testbench



---
 rtl/keyboard_ps2_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_keyboard_ps2_ctrl.sv | 465 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_ps2_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : keyboard_ps2_ctrl
// Purpose  : Host-side PS/2 keyboard sequencer: reset/BAT handshake, LED sync
//            and pass-through of scancodes to the decoder.
// Revision : 1.0 - initial release
// ============================================================================
module keyboard_ps2_ctrl #(
  parameter int ACK_TIMEOUT = 100000,
  parameter int BAT_TIMEOUT = 50000000,
  parameter int RETRIES     = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [0:7] rx_data,
  input  logic       rx_valid,
  output logic [0:7] tx_data,
  output logic       tx_start,
  input  logic       tx_busy,
  input  logic       alpha_state,
  input  logic       turbo_state,
  output logic [0:7] scancode,
  output logic       trigger,
  output logic       kbd_ready,
  output logic       kbd_error
);

  localparam int c_TMAX    = (ACK_TIMEOUT > BAT_TIMEOUT) ? ACK_TIMEOUT : BAT_TIMEOUT;
  localparam int c_TIMER_W = $clog2(c_TMAX) + 1;
  localparam int c_RETRY_W = $clog2(RETRIES + 1) + 1;

  localparam logic [c_TIMER_W-1:0] c_ACK_LIM   = c_TIMER_W'(ACK_TIMEOUT);
  localparam logic [c_TIMER_W-1:0] c_BAT_LIM   = c_TIMER_W'(BAT_TIMEOUT);
  localparam logic [c_TIMER_W-1:0] c_TIMER_MAX = '1;
  localparam logic [c_RETRY_W-1:0] c_RETRIES   = c_RETRY_W'(RETRIES);

  localparam logic [7:0] c_CMD_RESET    = 8'hFF;
  localparam logic [7:0] c_CMD_LEDS     = 8'hED;
  localparam logic [7:0] c_RSP_ACK      = 8'hFA;
  localparam logic [7:0] c_RSP_RESEND   = 8'hFE;
  localparam logic [7:0] c_RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] c_RSP_BAT_FAIL = 8'hFC;

  typedef enum logic [2:0] {
    S_RST_SEND     = 3'd0,
    S_RST_ACK      = 3'd1,
    S_RST_BAT      = 3'd2,
    S_IDLE         = 3'd3,
    S_LED_CMD      = 3'd4,
    S_LED_CMD_ACK  = 3'd5,
    S_LED_DATA     = 3'd6,
    S_LED_DATA_ACK = 3'd7
  } state_t;

  state_t                 r_state, w_state_nxt, w_resend_state;
  logic [c_TIMER_W-1:0]   r_timer, w_timer_nxt, w_timer_inc, w_timer_lim;
  logic [c_RETRY_W-1:0]   r_retry, w_retry_nxt;
  logic [2:0]             r_led_shadow, w_led_shadow_nxt;
  logic                   r_sync_pending, w_sync_pending_nxt;
  logic [7:0]             r_tx_data, w_tx_data_nxt;
  logic                   r_tx_start, w_tx_start_nxt;
  logic [7:0]             r_scancode, w_scancode_nxt;
  logic                   r_trigger, w_trigger_nxt;
  logic                   r_kbd_ready, w_kbd_ready_nxt;
  logic                   r_kbd_error, w_kbd_error_nxt;
  logic                   w_consumed, w_fail, w_expired, w_rx_ack, w_rx_resend;

  assign w_timer_inc = (r_timer == c_TIMER_MAX) ? r_timer : r_timer + 1'b1;
  assign w_timer_lim = (r_state == S_RST_BAT) ? c_BAT_LIM : c_ACK_LIM;
  assign w_expired   = (r_timer >= w_timer_lim);
  assign w_rx_ack    = rx_valid && (rx_data == c_RSP_ACK);
  assign w_rx_resend = rx_valid && (rx_data == c_RSP_RESEND);

  always_comb begin
    case (r_state)
      S_LED_CMD_ACK:  w_resend_state = S_LED_CMD;
      S_LED_DATA_ACK: w_resend_state = S_LED_DATA;
      default:        w_resend_state = S_RST_SEND;
    endcase
  end

  always_comb begin
    w_state_nxt        = r_state;
    w_timer_nxt        = r_timer;
    w_retry_nxt        = r_retry;
    w_led_shadow_nxt   = r_led_shadow;
    w_sync_pending_nxt = r_sync_pending;
    w_tx_data_nxt      = r_tx_data;
    w_tx_start_nxt     = 1'b0;
    w_kbd_ready_nxt    = r_kbd_ready;
    w_kbd_error_nxt    = r_kbd_error;
    w_consumed         = 1'b0;
    w_fail             = 1'b0;

    case (r_state)
      S_RST_SEND: begin
        if (!tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_tx_data_nxt  = c_CMD_RESET;
          w_timer_nxt    = '0;
          w_state_nxt    = S_RST_ACK;
        end
      end
      S_RST_ACK, S_LED_CMD_ACK, S_LED_DATA_ACK: begin
        w_timer_nxt = w_timer_inc;
        if (w_rx_ack) begin
          w_consumed  = 1'b1;
          w_retry_nxt = '0;
          case (r_state)
            S_RST_ACK: begin
              w_timer_nxt = '0;
              w_state_nxt = S_RST_BAT;
            end
            S_LED_CMD_ACK: w_state_nxt = S_LED_DATA;
            default:       w_state_nxt = S_IDLE;
          endcase
        end else if (w_rx_resend) begin
          w_consumed = 1'b1;
          w_fail     = 1'b1;
        end else if (!rx_valid && w_expired) begin
          // A byte arriving on the expiry cycle defers the timeout by one cycle
          w_fail = 1'b1;
        end
      end
      S_RST_BAT: begin
        w_timer_nxt = w_timer_inc;
        if (rx_valid && (rx_data == c_RSP_BAT_OK)) begin
          w_consumed         = 1'b1;
          w_retry_nxt        = '0;
          w_kbd_ready_nxt    = 1'b1;
          w_sync_pending_nxt = 1'b1;
          w_state_nxt        = S_LED_CMD;
        end else if (rx_valid && (rx_data == c_RSP_BAT_FAIL)) begin
          w_consumed = 1'b1;
          w_fail     = 1'b1;
        end else if (!rx_valid && w_expired) begin
          w_fail = 1'b1;
        end
      end
      S_IDLE: begin
        if (r_kbd_ready && (r_sync_pending ||
            ({alpha_state, turbo_state} != {r_led_shadow[2], r_led_shadow[0]}))) begin
          w_state_nxt = S_LED_CMD;
        end
      end
      S_LED_CMD: begin
        if (!tx_busy) begin
          w_tx_start_nxt     = 1'b1;
          w_tx_data_nxt      = c_CMD_LEDS;
          w_led_shadow_nxt   = {alpha_state, 1'b0, turbo_state};
          w_sync_pending_nxt = 1'b0;
          w_timer_nxt        = '0;
          w_state_nxt        = S_LED_CMD_ACK;
        end
      end
      S_LED_DATA: begin
        if (!tx_busy) begin
          w_tx_start_nxt = 1'b1;
          w_tx_data_nxt  = {5'b00000, r_led_shadow};
          w_timer_nxt    = '0;
          w_state_nxt    = S_LED_DATA_ACK;
        end
      end
      default: w_state_nxt = S_RST_SEND;
    endcase

    // Exhaustion clears the counter so the next command gets a full budget
    if (w_fail) begin
      if (r_retry < c_RETRIES) begin
        w_retry_nxt = r_retry + 1'b1;
        w_state_nxt = w_resend_state;
      end else begin
        w_retry_nxt     = '0;
        w_kbd_error_nxt = 1'b1;
        w_state_nxt     = S_IDLE;
      end
    end

    w_trigger_nxt  = rx_valid && !w_consumed;
    w_scancode_nxt = w_trigger_nxt ? rx_data : r_scancode;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_RST_SEND;
      r_timer        <= '0;
      r_retry        <= '0;
      r_led_shadow   <= '0;
      r_sync_pending <= 1'b0;
      r_tx_data      <= '0;
      r_tx_start     <= 1'b0;
      r_scancode     <= '0;
      r_trigger      <= 1'b0;
      r_kbd_ready    <= 1'b0;
      r_kbd_error    <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_timer        <= w_timer_nxt;
      r_retry        <= w_retry_nxt;
      r_led_shadow   <= w_led_shadow_nxt;
      r_sync_pending <= w_sync_pending_nxt;
      r_tx_data      <= w_tx_data_nxt;
      r_tx_start     <= w_tx_start_nxt;
      r_scancode     <= w_scancode_nxt;
      r_trigger      <= w_trigger_nxt;
      r_kbd_ready    <= w_kbd_ready_nxt;
      r_kbd_error    <= w_kbd_error_nxt;
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_start  = r_tx_start;
  assign scancode  = r_scancode;
  assign trigger   = r_trigger;
  assign kbd_ready = r_kbd_ready;
  assign kbd_error = r_kbd_error;

endmodule
`default_nettype wire

// File: tb/tb_keyboard_ps2_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_keyboard_ps2_ctrl
// Purpose  : Randomized scenario bench with a keyboard/transmitter model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_keyboard_ps2_ctrl;

  localparam int ACK_TO  = 50;
  localparam int BAT_TO  = 300;
  localparam int NRETRY  = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy = 1'b0;
  logic       alpha_state = 1'b0;
  logic       turbo_state = 1'b0;
  logic [7:0] scancode;
  logic       trigger;
  logic       kbd_ready;
  logic       kbd_error;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int busy_cnt = 0;
  bit m_alpha = 0;
  bit m_turbo = 0;

  logic [7:0] tx_q[$];
  int         tx_t[$];
  logic [7:0] trig_q[$];

  keyboard_ps2_ctrl #(
    .ACK_TIMEOUT(ACK_TO),
    .BAT_TIMEOUT(BAT_TO),
    .RETRIES    (NRETRY)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_start   (tx_start),
    .tx_busy    (tx_busy),
    .alpha_state(alpha_state),
    .turbo_state(turbo_state),
    .scancode   (scancode),
    .trigger    (trigger),
    .kbd_ready  (kbd_ready),
    .kbd_error  (kbd_error)
  );

  always #5 clk = ~clk;

  // Transmitter model and output monitor, sampled 1 time unit after the edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (tx_start) begin
      tx_q.push_back(tx_data);
      tx_t.push_back(cyc);
      busy_cnt = $urandom_range(2, 6);
    end
    if (trigger) trig_q.push_back(scancode);
    if (busy_cnt > 0) begin
      tx_busy  = 1'b1;
      busy_cnt = busy_cnt - 1;
    end else begin
      tx_busy = 1'b0;
    end
  end

  function automatic logic [7:0] exp_led(input bit a, input bit t);
    return 8'(a * 4 + t);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic reply(input logic [7:0] b);
    tick($urandom_range(0, 4));
    send_rx(b);
  endtask

  task automatic wait_tx(output logic [7:0] b, output int t, output bit ok, input int budget);
    ok = 1'b0;
    b  = '0;
    t  = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (tx_q.size() > 0) begin
        b  = tx_q.pop_front();
        t  = tx_t.pop_front();
        ok = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic set_leds(input bit a, input bit t);
    @(negedge clk);
    m_alpha     = a;
    m_turbo     = t;
    alpha_state = a;
    turbo_state = t;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({tx_start, trigger, kbd_ready, kbd_error} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags got %b want 0000", {tx_start, trigger, kbd_ready, kbd_error});
    end
    vectors++;
    if (tx_data !== 8'h00 || scancode !== 8'h00) begin
      miscompares++;
      $display("FAIL reset_bytes got tx=%h sc=%h want 00/00", tx_data, scancode);
    end
    vectors++;
    if (tx_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_no_tx got %0d sends want 0", tx_q.size());
    end
  endtask

  task automatic test_powerup();
    logic [7:0] b;
    int t;
    bit ok;
    set_leds($urandom_range(0, 1), $urandom_range(0, 1));
    tx_q.delete();
    trig_q.delete();
    @(negedge clk);
    reset = 1'b0;
    wait_tx(b, t, ok, 200);
    vectors++;
    if (!ok || b !== 8'hFF) begin
      miscompares++;
      $display("FAIL powerup_ff got %h (ok=%0d) want ff", b, ok);
    end
    reply(8'hFA);
    tick($urandom_range(5, 100));
    vectors++;
    if (kbd_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL powerup_ready_early got %b want 0", kbd_ready);
    end
    send_rx(8'hAA);
    vectors++;
    if (kbd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL powerup_ready got %b want 1", kbd_ready);
    end
    wait_tx(b, t, ok, 200);
    vectors++;
    if (!ok || b !== 8'hED) begin
      miscompares++;
      $display("FAIL powerup_ed got %h (ok=%0d) want ed", b, ok);
    end
    reply(8'hFA);
    wait_tx(b, t, ok, 200);
    vectors++;
    if (!ok || b !== exp_led(m_alpha, m_turbo)) begin
      miscompares++;
      $display("FAIL powerup_led got %h (ok=%0d) want %h", b, ok, exp_led(m_alpha, m_turbo));
    end
    reply(8'hFA);
    tick(5);
    vectors++;
    if (trig_q.size() != 0 || kbd_error !== 1'b0) begin
      miscompares++;
      $display("FAIL powerup_quiet got trig=%0d err=%b want 0/0", trig_q.size(), kbd_error);
    end
  endtask

  task automatic test_led_toggle();
    logic [7:0] b;
    int t;
    bit ok;
    int sel;
    for (int k = 0; k < 4; k++) begin
      sel = $urandom_range(1, 3);
      set_leds(m_alpha ^ sel[0], m_turbo ^ sel[1]);
      wait_tx(b, t, ok, 200);
      vectors++;
      if (!ok || b !== 8'hED) begin
        miscompares++;
        $display("FAIL toggle_ed got %h (ok=%0d) want ed", b, ok);
      end
      reply(8'hFA);
      wait_tx(b, t, ok, 200);
      vectors++;
      if (!ok || b !== exp_led(m_alpha, m_turbo)) begin
        miscompares++;
        $display("FAIL toggle_led got %h (ok=%0d) want %h", b, ok, exp_led(m_alpha, m_turbo));
      end
      reply(8'hFA);
      tick(3);
    end
    tick(20);
    vectors++;
    if (tx_q.size() != 0 || trig_q.size() != 0 || kbd_error !== 1'b0) begin
      miscompares++;
      $display("FAIL toggle_idle got tx=%0d trig=%0d err=%b want 0/0/0",
               tx_q.size(), trig_q.size(), kbd_error);
    end
  endtask

  task automatic test_fe_retry();
    logic [7:0] b;
    logic [7:0] want;
    int t;
    bit ok;
    int nfe;
    trig_q.delete();
    for (int round = 0; round < 2; round++) begin
      set_leds(~m_alpha, m_turbo);
      for (int phase = 0; phase < 2; phase++) begin
        nfe  = (round == 0) ? NRETRY : $urandom_range(1, NRETRY);
        want = (phase == 0) ? 8'hED : exp_led(m_alpha, m_turbo);
        for (int i = 0; i <= nfe; i++) begin
          wait_tx(b, t, ok, 200);
          vectors++;
          if (!ok || b !== want) begin
            miscompares++;
            $display("FAIL retry_send%0d got %h (ok=%0d) want %h", i, b, ok, want);
          end
          reply((i < nfe) ? 8'hFE : 8'hFA);
        end
      end
      tick(10);
      vectors++;
      if (kbd_error !== 1'b0 || trig_q.size() != 0 || tx_q.size() != 0) begin
        miscompares++;
        $display("FAIL retry_clean got err=%b trig=%0d tx=%0d want 0/0/0",
                 kbd_error, trig_q.size(), tx_q.size());
      end
    end
  endtask

  task automatic test_forward();
    logic [7:0] b;
    logic [7:0] bytes[4];
    int t;
    bit ok;
    set_leds(m_alpha, ~m_turbo);
    wait_tx(b, t, ok, 200);
    vectors++;
    if (!ok || b !== 8'hED) begin
      miscompares++;
      $display("FAIL fwd_ed got %h (ok=%0d) want ed", b, ok);
    end
    bytes[0] = 8'h1C;
    bytes[1] = 8'hF0;
    bytes[2] = 8'h1C;
    do bytes[3] = 8'($urandom_range(0, 255)); while (bytes[3] == 8'hFA || bytes[3] == 8'hFE);
    foreach (bytes[i]) begin
      @(negedge clk);
      rx_data  = bytes[i];
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (trigger !== 1'b1 || scancode !== bytes[i]) begin
        miscompares++;
        $display("FAIL fwd_byte%0d got trig=%b sc=%h want 1/%h", i, trigger, scancode, bytes[i]);
      end
      @(negedge clk);
      rx_valid = 1'b0;
      @(posedge clk);
      #1;
      vectors++;
      if (trigger !== 1'b0) begin
        miscompares++;
        $display("FAIL fwd_pulse%0d got trig=%b want 0", i, trigger);
      end
    end
    @(negedge clk);
    rx_data  = 8'hFA;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (trigger !== 1'b0) begin
      miscompares++;
      $display("FAIL fwd_fa_consumed got trig=%b want 0", trigger);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    wait_tx(b, t, ok, 200);
    vectors++;
    if (!ok || b !== exp_led(m_alpha, m_turbo)) begin
      miscompares++;
      $display("FAIL fwd_led got %h (ok=%0d) want %h", b, ok, exp_led(m_alpha, m_turbo));
    end
    reply(8'hFA);
    tick(5);
  endtask

  task automatic test_timeout();
    logic [7:0] b;
    logic [7:0] stray;
    int t;
    int prev;
    bit ok;
    prev = 0;
    tx_q.delete();
    tx_t.delete();
    set_leds(~m_alpha, m_turbo);
    for (int i = 0; i <= NRETRY; i++) begin
      wait_tx(b, t, ok, 3 * ACK_TO);
      vectors++;
      if (!ok || b !== 8'hED) begin
        miscompares++;
        $display("FAIL timeout_ed%0d got %h (ok=%0d) want ed", i, b, ok);
      end
      if (i > 0) begin
        vectors++;
        if ((t - prev) < ACK_TO || (t - prev) > ACK_TO + 20) begin
          miscompares++;
          $display("FAIL timeout_gap%0d got %0d want %0d..%0d", i, t - prev, ACK_TO, ACK_TO + 20);
        end
      end
      prev = t;
    end
    tick(2 * ACK_TO + 20);
    vectors++;
    if (tx_q.size() != 0) begin
      miscompares++;
      $display("FAIL timeout_extra_send got %0d want 0", tx_q.size());
    end
    vectors++;
    if (kbd_error !== 1'b1 || kbd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_flags got err=%b rdy=%b want 1/1", kbd_error, kbd_ready);
    end
    stray = 8'($urandom_range(0, 255));
    for (int i = 0; i < 2; i++) begin
      b = (i == 0) ? 8'hFA : stray;
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      vectors++;
      if (trigger !== 1'b1 || scancode !== b) begin
        miscompares++;
        $display("FAIL timeout_fwd%0d got trig=%b sc=%h want 1/%h", i, trigger, scancode, b);
      end
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    int t;
    bit ok;
    bit old_t;
    set_leds(~m_alpha, m_turbo);
    wait_tx(b, t, ok, 200);
    reply(8'hFA);
    wait_tx(b, t, ok, 200);
    vectors++;
    if (!ok || b !== exp_led(m_alpha, m_turbo)) begin
      miscompares++;
      $display("FAIL mid_led got %h (ok=%0d) want %h", b, ok, exp_led(m_alpha, m_turbo));
    end
    tick(2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    vectors++;
    if (tx_start !== 1'b0 || kbd_ready !== 1'b0 || kbd_error !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_reset got start=%b rdy=%b err=%b want 0/0/0", tx_start, kbd_ready, kbd_error);
    end
    @(negedge clk);
    tx_q.delete();
    tx_t.delete();
    reset = 1'b0;
    wait_tx(b, t, ok, 200);
    vectors++;
    if (!ok || b !== 8'hFF) begin
      miscompares++;
      $display("FAIL mid_ff got %h (ok=%0d) want ff", b, ok);
    end
    reply(8'hFA);
    tick($urandom_range(3, 50));
    send_rx(8'hAA);
    wait_tx(b, t, ok, 200);
    vectors++;
    if (!ok || b !== 8'hED) begin
      miscompares++;
      $display("FAIL mid_sync_ed got %h (ok=%0d) want ed", b, ok);
    end
    old_t = m_turbo;
    set_leds(m_alpha, ~m_turbo);
    reply(8'hFA);
    wait_tx(b, t, ok, 200);
    vectors++;
    if (!ok || b !== exp_led(m_alpha, old_t)) begin
      miscompares++;
      $display("FAIL mid_sync_led got %h (ok=%0d) want %h", b, ok, exp_led(m_alpha, old_t));
    end
    reply(8'hFA);
    wait_tx(b, t, ok, 20);
    vectors++;
    if (!ok || b !== 8'hED) begin
      miscompares++;
      $display("FAIL mid_resync_ed got %h (ok=%0d) want ed", b, ok);
    end
    reply(8'hFA);
    wait_tx(b, t, ok, 200);
    vectors++;
    if (!ok || b !== exp_led(m_alpha, m_turbo)) begin
      miscompares++;
      $display("FAIL mid_resync_led got %h (ok=%0d) want %h", b, ok, exp_led(m_alpha, m_turbo));
    end
    reply(8'hFA);
    tick(10);
    vectors++;
    if (tx_q.size() != 0 || kbd_error !== 1'b0 || kbd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_final got tx=%0d err=%b rdy=%b want 0/0/1", tx_q.size(), kbd_error, kbd_ready);
    end
  endtask

  initial begin
    test_reset();
    test_powerup();
    test_led_toggle();
    test_fe_retry();
    test_forward();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d want completion", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
